// File: rtl/azadi_board_pkg.sv
// rtl/azadi_board_pkg.sv - shared types and default sizing for the board input conditioner
package azadi_board_pkg;

  localparam int DefNumGpio         = 33;
  localparam int DefSyncStages      = 2;
  localparam int DefDebounceCycles  = 1000;
  localparam int DefResetHoldCycles = 64;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } board_rst_state_e;

  // One counter width covers both the debounce and the reset-hold counts.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/azadi_io_debounce_ch.sv
// rtl/azadi_io_debounce_ch.sv - one GPIO channel: synchroniser, debounce counter, level and edge registers
module azadi_io_debounce_ch
  import azadi_board_pkg::*;
#(
  parameter int SyncStages     = DefSyncStages,
  parameter int DebounceCycles = DefDebounceCycles,
  parameter int CntW           = cnt_width(DebounceCycles, 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  input  logic debounce_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic                  en_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_d;
  logic                  level_d;

  assign s = sync_q[SyncStages-1];

  // A mode change only clears the count; the level is held for that cycle.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    if (debounce_en == en_q) begin
      if (!debounce_en) begin
        level_d = s;
      end else if (s != level) begin
        if (cnt_q == CntLast) level_d = s;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      en_q   <= 1'b0;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad};
      en_q   <= debounce_en;
      cnt_q  <= cnt_d;
      level  <= level_d;
      rise   <= level_d & ~level;
      fall   <= ~level_d & level;
    end
  end

endmodule

// File: rtl/azadi_board_io_cond.sv
// rtl/azadi_board_io_cond.sv - GPIO conditioning array plus SoC reset sequencer driven by PLL lock
module azadi_board_io_cond
  import azadi_board_pkg::*;
#(
  parameter int NumGpio         = DefNumGpio,
  parameter int SyncStages      = DefSyncStages,
  parameter int DebounceCycles  = DefDebounceCycles,
  parameter int ResetHoldCycles = DefResetHoldCycles
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_locked_i,
  input  logic               soc_rst_req_i,
  input  logic [NumGpio-1:0] gpio_pad_i,
  input  logic [NumGpio-1:0] debounce_en_i,
  output logic [NumGpio-1:0] gpio_o,
  output logic [NumGpio-1:0] gpio_rise_o,
  output logic [NumGpio-1:0] gpio_fall_o,
  output logic               soc_rst_no,
  output logic               seq_busy_o
);

  localparam int              CntW     = cnt_width(DebounceCycles, ResetHoldCycles);
  localparam logic [CntW-1:0] HoldLast = CntW'(ResetHoldCycles - 1);

  for (genvar i = 0; i < NumGpio; i++) begin : g_ch
    azadi_io_debounce_ch #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .CntW          (CntW)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .pad        (gpio_pad_i[i]),
      .debounce_en(debounce_en_i[i]),
      .level      (gpio_o[i]),
      .rise       (gpio_rise_o[i]),
      .fall       (gpio_fall_o[i])
    );
  end

  logic [1:0]       lock_sync_q;
  logic             lock_s;
  board_rst_state_e state_q;
  board_rst_state_e state_d;
  logic [CntW-1:0]  hold_cnt_q;
  logic [CntW-1:0]  hold_cnt_d;

  assign lock_s = lock_sync_q[1];

  // Lock loss outranks a reset request, which outranks normal progress.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (!lock_s) begin
      state_d    = WAIT_LOCK;
      hold_cnt_d = '0;
    end else if (soc_rst_req_i && (state_q != WAIT_LOCK)) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
        HOLD: begin
          if (hold_cnt_q == HoldLast) begin
            state_d    = RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CntW'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_sync_q <= '0;
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      soc_rst_no  <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_rst_no  <= (state_d == RUN);
    end
  end

  assign seq_busy_o = (state_q != RUN);

endmodule

// File: tb/tb_azadi_board_io_cond.sv
// tb/tb_azadi_board_io_cond.sv - directed bench for GPIO conditioning and reset sequencing
module tb_azadi_board_io_cond;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       soc_rst_req;
  logic [7:0] gpio_pad;
  logic [7:0] debounce_en;
  logic [7:0] gpio;
  logic [7:0] gpio_rise;
  logic [7:0] gpio_fall;
  logic       soc_rst_n;
  logic       seq_busy;

  int checks   = 0;
  int failures = 0;
  logic [13:0] glitch_pat;

  azadi_board_io_cond #(
    .NumGpio        (8),
    .SyncStages     (2),
    .DebounceCycles (4),
    .ResetHoldCycles(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_locked_i (pll_locked),
    .soc_rst_req_i(soc_rst_req),
    .gpio_pad_i   (gpio_pad),
    .debounce_en_i(debounce_en),
    .gpio_o       (gpio),
    .gpio_rise_o  (gpio_rise),
    .gpio_fall_o  (gpio_fall),
    .soc_rst_no   (soc_rst_n),
    .seq_busy_o   (seq_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b1; soc_rst_req = 1'b0;
    gpio_pad = 8'h00; debounce_en = 8'h01;
    tick(2);
    gpio_pad = 8'hFF;
    tick(3);
    check("rst_gpio", gpio, 8'h00);
    check("rst_rise", gpio_rise, 8'h00);
    check("rst_fall", gpio_fall, 8'h00);
    check("rst_soc", soc_rst_n, 1'b0);
    check("rst_busy", seq_busy, 1'b1);
    gpio_pad = 8'h00;
    tick(1);

    // reset release with lock high: soc reset lifts on the 11th edge
    reset = 1'b0;
    tick(10);
    check("rel_soc_early", {seq_busy, soc_rst_n}, 2'b10);
    tick(1);
    check("rel_soc_run", {seq_busy, soc_rst_n}, 2'b01);

    // clean press on debounced channel 0
    gpio_pad[0] = 1'b1;
    tick(5);
    check("press_early", gpio, 8'h00);
    tick(1);
    check("press_level", gpio, 8'h01);
    check("press_rise", gpio_rise, 8'h01);
    tick(1);
    check("press_rise_once", gpio_rise, 8'h00);
    gpio_pad[0] = 1'b0;
    tick(6);
    check("release_level", gpio, 8'h00);
    check("release_fall", gpio_fall, 8'h01);
    tick(1);
    check("release_fall_once", gpio_fall, 8'h00);

    // glitches of 3 high, 1 low, 3 high must never pass
    glitch_pat = 14'b00000001110111;
    for (int k = 0; k < 14; k++) begin
      gpio_pad[0] = glitch_pat[k];
      tick(1);
      check("glitch", {gpio_rise[0], gpio_fall[0], gpio[0]}, 3'b000);
    end

    // bypass channel 5: single-cycle pulse after 3 edges
    gpio_pad[5] = 1'b1;
    tick(1);
    gpio_pad[5] = 1'b0;
    tick(1);
    check("byp_early", gpio, 8'h00);
    tick(1);
    check("byp_level", gpio, 8'h20);
    check("byp_rise", gpio_rise, 8'h20);
    tick(1);
    check("byp_low", gpio, 8'h00);
    check("byp_fall", gpio_fall, 8'h20);

    // mode switch mid-count clears the count and holds the level
    gpio_pad[5] = 1'b1;
    tick(3);
    check("mode_pre", gpio, 8'h20);
    debounce_en[5] = 1'b1;
    gpio_pad[5] = 1'b0;
    tick(4);
    check("mode_counting", gpio, 8'h20);
    debounce_en[5] = 1'b0;
    tick(1);
    check("mode_to_bypass_hold", gpio, 8'h20);
    debounce_en[5] = 1'b1;
    tick(4);
    check("mode_recount", gpio, 8'h20);
    tick(1);
    check("mode_level", gpio, 8'h00);
    check("mode_fall", gpio_fall, 8'h20);

    // lock loss and restore
    pll_locked = 1'b0;
    tick(2);
    check("lock_loss_early", soc_rst_n, 1'b1);
    tick(1);
    check("lock_loss", {seq_busy, soc_rst_n}, 2'b10);
    pll_locked = 1'b1;
    tick(10);
    check("relock_early", soc_rst_n, 1'b0);
    tick(1);
    check("relock_run", {seq_busy, soc_rst_n}, 2'b01);

    // one-cycle lock loss coinciding with a request: lock loss wins
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    soc_rst_req = 1'b1;
    tick(1);
    soc_rst_req = 1'b0;
    check("simul_soc", {seq_busy, soc_rst_n}, 2'b10);
    tick(8);
    check("simul_still_held", soc_rst_n, 1'b0);
    tick(1);
    check("simul_run", {seq_busy, soc_rst_n}, 2'b01);

    // request in RUN, then again in HOLD at count 6
    soc_rst_req = 1'b1;
    tick(1);
    soc_rst_req = 1'b0;
    check("req_soc_low", {seq_busy, soc_rst_n}, 2'b10);
    tick(6);
    soc_rst_req = 1'b1;
    tick(1);
    soc_rst_req = 1'b0;
    tick(7);
    check("req_restart_held", soc_rst_n, 1'b0);
    tick(1);
    check("req_restart_run", {seq_busy, soc_rst_n}, 2'b01);

    // async reset two cycles into a debounce count
    debounce_en = 8'h01;
    gpio_pad = 8'h21;
    tick(4);
    check("areset_pre", gpio, 8'h20);
    reset = 1'b1;
    #1;
    check("areset_gpio", gpio, 8'h00);
    check("areset_edges", {gpio_rise, gpio_fall}, 16'h0000);
    check("areset_seq", {seq_busy, soc_rst_n}, 2'b10);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("areset_post_early", gpio, 8'h00);
    tick(1);
    check("areset_byp", gpio, 8'h20);
    check("areset_byp_rise", gpio_rise, 8'h20);
    tick(2);
    check("areset_db_early", gpio, 8'h20);
    tick(1);
    check("areset_db_level", gpio, 8'h21);
    check("areset_db_rise", gpio_rise, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
